pc_register: RTL and testbench



---
 rtl/pc_register.sv | 27 ++
 tb/tb_pc_register.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_register.sv
// Program counter storage for the fetch stage.
// Loads the next-PC candidate on write enable, otherwise holds.
module pc_register #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] mux1op,
  input  logic             PCCR,
  output logic [WIDTH-1:0] PCa
);

  logic [WIDTH-1:0] pc;

  // A ternary select lets an unknown enable show up as X on
  // the PC, instead of an if/else that would quietly hold.
  always_ff @(posedge clk) begin
    if (!rst)
      pc <= RESET_VALUE;
    else
      pc <= PCCR ? mux1op : pc;
  end

  assign PCa = pc;

endmodule

// File: tb/tb_pc_register.sv
// Directed vector bench for pc_register.
// Table-driven edges plus hand-written mid-cycle sequences.
module tb_pc_register;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         pccr;
  logic [W-1:0] mux1op;
  logic [W-1:0] pca;

  int n_checks = 0;
  int n_fail   = 0;

  pc_register #(
    .WIDTH(W),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mux1op(mux1op),
    .PCCR  (pccr),
    .PCa   (pca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         pccr;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] exp);
    n_checks++;
    if (pca !== exp) begin
      n_fail++;
      $display("FAIL %s: PCa=%h expected %h", name, pca, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic [W-1:0] d);
    rst    = r;
    pccr   = e;
    mux1op = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b1, 8'h07);

    vecs.push_back('{"reset_e1",   1'b0, 1'b1, 8'h07, 8'h00});
    vecs.push_back('{"reset_e2",   1'b0, 1'b1, 8'h07, 8'h00});
    vecs.push_back('{"load_07",    1'b1, 1'b1, 8'h07, 8'h07});
    vecs.push_back('{"hold_1",     1'b1, 1'b0, 8'h55, 8'h07});
    vecs.push_back('{"hold_2",     1'b1, 1'b0, 8'h55, 8'h07});
    vecs.push_back('{"hold_3",     1'b1, 1'b0, 8'h55, 8'h07});
    vecs.push_back('{"b2b_01",     1'b1, 1'b1, 8'h01, 8'h01});
    vecs.push_back('{"b2b_02",     1'b1, 1'b1, 8'h02, 8'h02});
    vecs.push_back('{"b2b_ff",     1'b1, 1'b1, 8'hFF, 8'hFF});
    vecs.push_back('{"b2b_00",     1'b1, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"load_c3",    1'b1, 1'b1, 8'hC3, 8'hC3});
    vecs.push_back('{"prio_rst",   1'b0, 1'b1, 8'hAA, 8'h00});
    vecs.push_back('{"rst_hold",   1'b0, 1'b0, 8'h3C, 8'h00});
    vecs.push_back('{"load_2a",    1'b1, 1'b1, 8'h2A, 8'h2A});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].pccr, vecs[i].d);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // New load value is not visible before the edge.
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h33);
    #1;
    check("pre_edge_hold", 8'h2A);
    @(posedge clk);
    #1;
    check("post_edge_33", 8'h33);

    // Input wiggles between edges are ignored.
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h99);
    #2 mux1op = 8'h44;
    #1 pccr = 1'b1;
    #1 pccr = 1'b0;
    @(posedge clk);
    #1;
    check("between_edges", 8'h33);

    // Synchronous reset asserted mid-cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h2A);
    @(posedge clk);
    #1;
    check("sync_pre_2a", 8'h2A);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("sync_rst_mid", 8'h2A);
    @(posedge clk);
    #1;
    check("sync_rst_edge", 8'h00);

    // Release reset and load on the following edge.
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h10);
    #1;
    check("release_pre", 8'h00);
    @(posedge clk);
    #1;
    check("release_load", 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
